uart_tx_arbiter: RTL

Shares the single UART transmitter between two byte-stream sources, e.g. the result reporter and the auxiliary console path inside `toplevel_bruteforcer`. Each source streams multi-byte packets framed by a `last` flag. A packet is never interleaved with another. Grants alternate round-robin between packets, and an idle-timeout releases a source that stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two packetised byte sources.
// A granted source keeps the lock until its last byte is accepted or it stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_byte,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_byte,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_byte,
  output logic       tx_req,
  input  logic       tx_busy,
  output logic       owner,
  output logic       locked,
  output logic       timeout_evt
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_OWN      = 1'b1;
  localparam logic [15:0] TIMEOUT_CNT = 16'(IDLE_TIMEOUT);

  logic [0:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic        tx_req_q, tx_req_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]  src_valid;
  logic [1:0]  src_last;
  logic [1:0]  src_ready;
  logic [7:0]  src_byte [2];

  logic        slot_free;
  logic        own_valid;
  logic        own_last;
  logic        handshake;
  logic [15:0] cnt_inc;
  logic        cnt_hit;

  assign src_valid   = {s1_valid, s0_valid};
  assign src_last    = {s1_last, s0_last};
  assign src_byte[0] = s0_byte;
  assign src_byte[1] = s1_byte;

  // The cycle carrying tx_req is a guard cycle: the UART has not yet raised tx_busy.
  assign slot_free = (state_q == ST_OWN) && !tx_busy && !tx_req_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign src_ready[gi] = slot_free && (owner_q == 1'(gi));
  end

  assign own_valid = src_valid[owner_q];
  assign own_last  = src_last[owner_q];
  assign handshake = own_valid && src_ready[owner_q];
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign cnt_hit   = (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    tx_req_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|src_valid) begin
          owner_d = (&src_valid) ? rr_q : src_valid[1];
          state_d = ST_OWN;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (handshake) begin
          tx_byte_d = src_byte[owner_q];
          tx_req_d  = 1'b1;
          cnt_d     = '0;
          if (own_last) begin
            state_d = ST_IDLE;
            rr_d    = ~owner_q;
          end
        end else if (!own_valid) begin
          // Only a silent owner ages the lock; a source blocked by the UART does not.
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            state_d   = ST_IDLE;
            rr_d      = ~owner_q;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      tx_byte_q <= 8'h00;
      tx_req_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      tx_req_q  <= tx_req_d;
      timeout_q <= timeout_d;
    end
  end

  assign s0_ready    = src_ready[0];
  assign s1_ready    = src_ready[1];
  assign tx_byte     = tx_byte_q;
  assign tx_req      = tx_req_q;
  assign owner       = owner_q;
  assign locked      = (state_q == ST_OWN);
  assign timeout_evt = timeout_q;

endmodule
